// File: rtl/mac_seq_pkg.sv
// Shared arithmetic package: default operand/accumulator/length widths and
// the dot-product sequencer state encoding.
package mac_seq_pkg;

  localparam int unsigned DW_DEF   = 16;
  localparam int unsigned ACCW_DEF = 40;
  localparam int unsigned LENW_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_e;

endpackage

// File: rtl/mac_seq.sv
// Dot-product sequencer: feeds operand pairs to an external MAC, waits for
// its pipeline to settle, then presents the accumulator as a result.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned ACCW = ACCW_DEF,
  parameter int unsigned LENW = LENW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] len,
  output logic            busy,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_a,
  input  logic [DW-1:0]   in_b,
  output logic            mac_clear,
  output logic            mac_en,
  output logic [DW-1:0]   mac_a,
  output logic [DW-1:0]   mac_b,
  input  logic [ACCW-1:0] mac_acc,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [ACCW-1:0] res_data
);

  state_e          state_q, state_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic            drain_q, drain_d;
  logic            mac_clear_q, mac_clear_d;
  logic            mac_en_q, mac_en_d;
  logic [DW-1:0]   mac_a_q, mac_a_d;
  logic [DW-1:0]   mac_b_q, mac_b_d;
  logic [ACCW-1:0] res_data_q, res_data_d;
  logic            accept;

  assign accept = in_valid & (state_q == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drain_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = len;
          state_d = S_CLR;
        end
      end
      S_CLR:   state_d = (rem_q != '0) ? S_RUN : S_DRAIN;
      S_RUN: begin
        if (accept) begin
          rem_d = rem_q - LENW'(1);
          if (rem_q == LENW'(1)) state_d = S_DRAIN;
        end
      end
      // Two drain cycles cover the registered enable plus the MAC's own register.
      S_DRAIN: begin
        if (drain_q) state_d = S_OUT;
        else         drain_d = 1'b1;
      end
      S_OUT:   if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    in_ready    = (state_q == S_RUN);
    res_valid   = (state_q == S_OUT);
    mac_clear_d = (state_q == S_CLR);
    mac_en_d    = accept;
    mac_a_d     = accept ? in_a : '0;
    mac_b_d     = accept ? in_b : '0;
    res_data_d  = res_data_q;
    if (state_q == S_DRAIN && drain_q) res_data_d = mac_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q       <= '0;
      drain_q     <= 1'b0;
      mac_clear_q <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_data_q  <= '0;
    end else begin
      rem_q       <= rem_d;
      drain_q     <= drain_d;
      mac_clear_q <= mac_clear_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_data_q  <= res_data_d;
    end
  end

  assign mac_clear = mac_clear_q;
  assign mac_en    = mac_en_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: external MAC stand-in, timeline-based reference model
// checked every cycle, directed scenarios with literal results, random traffic.
module tb_mac_seq;

  localparam int unsigned DW   = 16;
  localparam int unsigned ACCW = 40;
  localparam int unsigned LENW = 8;
  localparam longint unsigned MASK = (64'd1 << ACCW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [LENW-1:0] len = '0;
  logic            busy;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_a = '0;
  logic [DW-1:0]   in_b = '0;
  logic            mac_clear;
  logic            mac_en;
  logic [DW-1:0]   mac_a;
  logic [DW-1:0]   mac_b;
  logic [ACCW-1:0] mac_acc = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [ACCW-1:0] res_data;

  int n_tests = 0;
  int n_fail  = 0;

  mac_seq #(.DW(DW), .ACCW(ACCW), .LENW(LENW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_clear(mac_clear), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Downstream MAC: clear has priority, modulo-2^ACCW accumulate.
  logic [ACCW-1:0] ext_a, ext_b;
  assign ext_a = ACCW'(mac_a);
  assign ext_b = ACCW'(mac_b);
  always @(posedge clk) begin
    if (rst || mac_clear) mac_acc <= '0;
    else if (mac_en)      mac_acc <= mac_acc + ext_a * ext_b;
  end

  function automatic void chk(string name, longint unsigned act, longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: one operation tracked by its timeline.
  // start seen in cycle ts -> CLR ts+1, operands accepted from ts+2,
  // last accept tl -> result visible from tl+3 (len=0 behaves as tl=ts+1).
  int              cyc = 0;
  bit              active = 0;
  int              t_start = 0;
  int              t_last = 0;
  bit              has_last = 0;
  int              n_left = 0;
  longint unsigned sum = 0;
  bit              x_busy = 0, x_ready = 0, x_valid = 0, x_clear = 0, x_en = 0;
  longint unsigned x_a = 0, x_b = 0, x_res = 0;

  function automatic bit ready_at(int t);
    return active && (t >= t_start + 2) && (n_left > 0);
  endfunction

  function automatic bit valid_at(int t);
    return active && has_last && (t >= t_last + 3);
  endfunction

  always @(posedge clk) begin
    bit acc_now, was_active;
    int c;
    c = cyc;
    if (rst) begin
      active = 0; x_en = 0; x_a = 0; x_b = 0; x_clear = 0; x_res = 0;
    end else begin
      was_active = active;
      acc_now    = ready_at(c) && in_valid;
      x_en       = acc_now;
      x_a        = acc_now ? longint'(in_a) : 0;
      x_b        = acc_now ? longint'(in_b) : 0;
      x_clear    = active && (c == t_start + 1);
      if (acc_now) begin
        sum = (sum + longint'(in_a) * longint'(in_b)) & MASK;
        n_left--;
        if (n_left == 0) begin t_last = c; has_last = 1; end
      end
      if (valid_at(c) && res_ready) active = 0;
      if (!was_active && start) begin
        active   = 1;
        t_start  = c;
        n_left   = int'(len);
        sum      = 0;
        has_last = (len == 0);
        t_last   = c + 1;
      end
      if (active && has_last && (c + 1 == t_last + 3)) x_res = sum;
    end
    cyc     = c + 1;
    x_busy  = active && (cyc > t_start);
    x_ready = ready_at(cyc);
    x_valid = valid_at(cyc);
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy",      busy,      x_busy);
      chk("in_ready",  in_ready,  x_ready);
      chk("res_valid", res_valid, x_valid);
      chk("mac_clear", mac_clear, x_clear);
      chk("mac_en",    mac_en,    x_en);
      chk("mac_a",     mac_a,     x_a);
      chk("mac_b",     mac_b,     x_b);
      chk("res_data",  res_data,  x_res);
    end
  end

  int en_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #2;
    if (mac_en) en_cnt++;
  endtask

  task automatic wait_valid(output int t);
    int k = 0;
    while (!res_valid && k < 50) begin tick(); k++; end
    chk("res_valid_timeout", res_valid, 1);
    t = cyc;
  endtask

  task automatic begin_op(input int n);
    start = 1'b1; len = LENW'(n);
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_mac_clear"}, mac_clear, 0);
    chk({tag, "_mac_en"},    mac_en,    0);
    chk({tag, "_mac_a"},     mac_a,     0);
    chk({tag, "_mac_b"},     mac_b,     0);
    chk({tag, "_res_data"},  res_data,  0);
  endtask

  initial begin
    int t, la, ls;
    tick(); tick();
    chk_all_zero("por");
    rst = 1'b0;
    res_ready = 1'b1;
    tick();

    // (1,4),(2,5),(3,6) back to back
    begin_op(3);
    in_valid = 1'b1; in_a = 1; in_b = 4; tick();
    in_a = 2; in_b = 5; tick();
    in_a = 3; in_b = 6; la = cyc; tick();
    in_valid = 1'b0;
    wait_valid(t);
    chk("dot3_lat", longint'(t - la), 3);
    chk("dot3_res", res_data, 32);
    chk("dot3_model", x_res, 32);
    tick();
    chk("dot3_idle", busy, 0);

    // len = 0
    start = 1'b1; len = '0; ls = cyc; tick();
    start = 1'b0;
    wait_valid(t);
    chk("len0_lat", longint'(t - ls), 4);
    chk("len0_res", res_data, 0);
    tick();

    // gapped in_valid, (7,7) x4
    en_cnt = 0;
    begin_op(4);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 3 == 0); in_a = 7; in_b = 7;
      if (k == 9) la = cyc;
      tick();
    end
    in_valid = 1'b0;
    wait_valid(t);
    chk("gap_lat", longint'(t - la), 3);
    chk("gap_res", res_data, 196);
    chk("gap_model", x_res, 196);
    chk("gap_en_pulses", en_cnt, 4);
    tick();

    // OUT back-pressure with start pulsed
    res_ready = 1'b0;
    begin_op(1);
    in_valid = 1'b1; in_a = 5; in_b = 6; tick();
    in_valid = 1'b0;
    wait_valid(t);
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; len = 7;
      chk("hold_res", res_data, 30);
      chk("hold_busy", busy, 1);
      chk("hold_valid", res_valid, 1);
      tick();
    end
    res_ready = 1'b1; start = 1'b1; tick();
    start = 1'b0;
    chk("hs_idle", busy, 0);
    tick();
    chk("hs_no_restart", busy, 0);

    // len=255, all 0xFFFF
    begin_op(255);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'hFFFF;
    for (int k = 0; k < 255; k++) begin
      if (k == 254) la = cyc;
      tick();
    end
    in_valid = 1'b0;
    wait_valid(t);
    chk("max_lat", longint'(t - la), 3);
    chk("max_res", res_data, 64'd1095183237375);
    tick();

    // reset mid-RUN, then fresh op
    begin_op(5);
    in_valid = 1'b1; in_a = 2; in_b = 2; tick(); tick();
    rst = 1'b1; tick();
    chk_all_zero("rst_run");
    rst = 1'b0; in_valid = 1'b0;
    begin_op(1);
    in_valid = 1'b1; in_a = 3; in_b = 3; tick();
    in_valid = 1'b0;
    wait_valid(t);
    chk("post_rst_res", res_data, 9);
    tick();

    // random traffic, occasional resets and spurious starts
    for (int k = 0; k < 2500; k++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 3) == 0);
      len       = ($urandom_range(0, 4) == 0) ? '0 : LENW'($urandom_range(1, 12));
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : DW'($urandom);
      in_b      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : DW'($urandom);
      res_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 The parameter list SHALL be: DW, 16, operand width (matches downstream MAC); ACCW, 40, accumulator/result width; LENW, 8, vector-length width.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new dot product; sampled only in IDLE.
REQ-005 len  input  LENW  number of operand pairs, captured with start.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 in_valid  input  1  operand pair valid.
REQ-008 in_ready  output  1  sequencer accepts the pair this cycle.
REQ-009 in_a, in_b  input  DW each  unsigned operands.
REQ-010 mac_clear  output  1  registered clear to MAC.
REQ-011 mac_en  output  1  registered enable to MAC.
REQ-012 mac_a, mac_b  output  DW each  registered operands to MAC.
REQ-013 mac_acc  input  ACCW  MAC accumulator value.
REQ-014 res_valid  output  1  result valid.
REQ-015 res_ready  input  1  result consumer ready.
REQ-016 res_data  output  ACCW  captured dot-product result.

Function
REQ-017 States SHALL be IDLE, CLR, RUN, DRAIN, OUT.
REQ-018 IDLE: start=1 SHALL load remaining=len and go CLR; start=0 stays IDLE.
REQ-019 CLR lasts exactly one cycle; mac_clear SHALL be 1 in the following cycle; next state RUN if len!=0, else DRAIN.
REQ-020 in_ready SHALL be 1 only in RUN; accept = in_valid & in_ready.
REQ-021 On accept, the next cycle SHALL show mac_en=1, mac_a=in_a, mac_b=in_b; otherwise mac_en=0 and mac_a/mac_b=0.
REQ-022 Each accept SHALL decrement remaining; the accept taking remaining from 1 to 0 SHALL move to DRAIN.
REQ-023 in_valid gaps in RUN SHALL stall without side effects.
REQ-024 DRAIN SHALL last exactly 2 cycles; at the end of the second, res_data SHALL capture mac_acc and the FSM SHALL go to OUT.
REQ-025 Latency: last accept in cycle t SHALL give res_valid=1 in cycle t+3.
REQ-026 OUT: res_valid=1 and res_data SHALL hold stable until res_ready=1; that cycle completes transfer and returns to IDLE.
REQ-027 start SHALL be ignored in all states other than IDLE, including the OUT cycle where res_ready=1.
REQ-028 len=0 SHALL produce res_data=0 without accepting any operand.
REQ-029 Arithmetic is unsigned; the sequencer SHALL NOT modify or saturate mac_acc, and wrap is the MAC's modulo-2^ACCW behaviour.

Reset
REQ-030 rst=1 SHALL force IDLE, remaining=0, and in_ready, busy, mac_clear, mac_en, res_valid=0, with mac_a, mac_b, res_data=0, in any state.
REQ-031 Reset mid-RUN or mid-OUT SHALL discard the operation; the next start SHALL behave as from power-up.

Structure
REQ-032 The state encoding and the default DW/ACCW/LENW constants SHALL live in the shared arithmetic package.
REQ-033 No sub-module SHALL be instantiated; the parent instantiates mac beside mac_seq and wires mac_clear/mac_en/mac_a/mac_b/mac_acc.

Verification
REQ-034 len=3, pairs (1,4),(2,5),(3,6) back-to-back, res_ready=1 -> res_data=32, res_valid exactly 3 cycles after third accept.
REQ-035 len=0 -> in_ready never 1, res_data=0, res_valid 4 cycles after start (CLR, 2xDRAIN, OUT).
REQ-036 len=4, in_valid toggling 1,0,0,1,... with pairs (7,7) -> res_data=196; mac_en pulses equal accepts.
REQ-037 res_ready low 5 cycles in OUT with start pulsed -> res_data stable, busy=1, start ignored, IDLE after handshake.
REQ-038 len=255, all pairs (0xFFFF,0xFFFF) -> res_data=1095183237375 (fits 40 bits).
REQ-039 rst pulsed after 2 of 5 accepts -> all outputs 0 next cycle; new len=1 (3,3) -> res_data=9.
